// File: rtl/vnu_iter_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// vnu_iter_ctrl_fsm
//
// Per-codeword iteration controller that sits directly upstream of the VNU
// write-update handshake. For each codeword it runs:
//
//   IDLE -> INIT_LOAD -> { VNU_RD -> WR_WAIT -> ITER_UP } x N -> DONE -> IDLE
//
// It drives the handshake strobes (vnu_init_load_en_o, vnu_rd_finish_o,
// iter_update_o) and consumes the handshake's replies (init_load_i, vnu_wr_i).
// Decoding ends after MAX_ITER iterations, on an all-zero syndrome
// (early_stop_i sampled in ITER_UP), or on a WR_WAIT timeout. A timeout sets
// the sticky err_o flag.
//
// Parameters
//   MAX_ITER   : maximum decoding iterations per codeword (>= 1)
//   ITER_W     : iteration counter width (2**ITER_W > MAX_ITER)
//   RD_CYCLES  : LUT-chain read cycles per iteration (>= 1)
//   RD_CNT_W   : read-cycle counter width (2**RD_CNT_W >= RD_CYCLES)
//   WR_TIMEOUT : cycles allowed in WR_WAIT before aborting (>= 1)
//
// Ports
//   read_clk           in  decoder clock, rising edge
//   rstn               in  asynchronous active-low reset
//   start_i            in  start pulse, accepted in IDLE only
//   early_stop_i       in  syndrome all-zero flag, sampled in ITER_UP only
//   vnu_wr_i           in  write acknowledge from the handshake stage
//   init_load_i        in  initial-load acknowledge from the handshake stage
//   pipe_load_i        in  pipeline-load status, observed only
//   vnu_init_load_en_o out high while in INIT_LOAD
//   vnu_rd_en_o        out high while in VNU_RD
//   vnu_rd_finish_o    out high while in WR_WAIT
//   iter_update_o      out high for the ITER_UP cycle
//   iter_cnt_o         out completed iterations of the current codeword
//   busy_o             out high in every state except IDLE
//   done_o             out high for the DONE cycle
//   err_o              out sticky WR_WAIT timeout flag, cleared by next start
// -----------------------------------------------------------------------------
module vnu_iter_ctrl_fsm #(
    parameter int MAX_ITER   = 10,
    parameter int ITER_W     = 4,
    parameter int RD_CYCLES  = 4,
    parameter int RD_CNT_W   = 3,
    parameter int WR_TIMEOUT = 15
) (
    input  logic              read_clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic              early_stop_i,
    input  logic              vnu_wr_i,
    input  logic              init_load_i,
    input  logic              pipe_load_i,
    output logic              vnu_init_load_en_o,
    output logic              vnu_rd_en_o,
    output logic              vnu_rd_finish_o,
    output logic              iter_update_o,
    output logic [ITER_W-1:0] iter_cnt_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    // The wait counter only has to reach WR_TIMEOUT-1.
    localparam int WAIT_W = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT) : 1;

    localparam logic [RD_CNT_W-1:0] RD_LAST   = RD_CNT_W'(RD_CYCLES - 1);
    localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(WR_TIMEOUT - 1);
    localparam logic [ITER_W-1:0]   ITER_LAST = ITER_W'(MAX_ITER - 1);
    localparam logic [ITER_W-1:0]   ITER_MAX  = ITER_W'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT_LOAD = 3'd1,
        S_VNU_RD    = 3'd2,
        S_WR_WAIT   = 3'd3,
        S_ITER_UP   = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t              state_q,    state_d;
    logic [RD_CNT_W-1:0] rd_cnt_q,   rd_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [ITER_W-1:0]   iter_cnt_q, iter_cnt_d;
    logic                err_q,      err_d;

    // Registered per-state strobes. They are loaded from the next-state
    // decode so each one is high exactly while the FSM sits in its state.
    logic vnu_init_load_en_q;
    logic vnu_rd_en_q;
    logic vnu_rd_finish_q;
    logic iter_update_q;
    logic busy_q;
    logic done_q;

    // pipe_load_i carries status only and never steers the sequence.
    logic unused_pipe_load;
    assign unused_pipe_load = pipe_load_i;

    // -------------------------------------------------------------------------
    // Next-state and counter logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        wait_cnt_d = wait_cnt_q;
        iter_cnt_d = iter_cnt_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_INIT_LOAD;
                    iter_cnt_d = '0;
                    err_d      = 1'b0;
                    rd_cnt_d   = '0;
                    wait_cnt_d = '0;
                end
            end

            S_INIT_LOAD: begin
                if (init_load_i) begin
                    state_d  = S_VNU_RD;
                    rd_cnt_d = '0;
                end
            end

            S_VNU_RD: begin
                if (rd_cnt_q == RD_LAST) begin
                    state_d    = S_WR_WAIT;
                    rd_cnt_d   = '0;
                    wait_cnt_d = '0;
                end else begin
                    rd_cnt_d = rd_cnt_q + RD_CNT_W'(1);
                end
            end

            S_WR_WAIT: begin
                // An acknowledge in the final allowed cycle still wins over
                // the timeout.
                if (vnu_wr_i) begin
                    state_d    = S_ITER_UP;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = S_DONE;
                    err_d      = 1'b1;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            S_ITER_UP: begin
                if (iter_cnt_q < ITER_MAX) begin
                    iter_cnt_d = iter_cnt_q + ITER_W'(1);
                end
                // Early stop on the last iteration still ends in a single
                // DONE with the count incremented once.
                if (early_stop_i || (iter_cnt_q >= ITER_LAST)) begin
                    state_d = S_DONE;
                end else begin
                    state_d  = S_VNU_RD;
                    rd_cnt_d = '0;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d    = S_IDLE;
                rd_cnt_d   = '0;
                wait_cnt_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counters and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            state_q            <= S_IDLE;
            rd_cnt_q           <= '0;
            wait_cnt_q         <= '0;
            iter_cnt_q         <= '0;
            err_q              <= 1'b0;
            vnu_init_load_en_q <= 1'b0;
            vnu_rd_en_q        <= 1'b0;
            vnu_rd_finish_q    <= 1'b0;
            iter_update_q      <= 1'b0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
        end else begin
            state_q            <= state_d;
            rd_cnt_q           <= rd_cnt_d;
            wait_cnt_q         <= wait_cnt_d;
            iter_cnt_q         <= iter_cnt_d;
            err_q              <= err_d;
            vnu_init_load_en_q <= (state_d == S_INIT_LOAD);
            vnu_rd_en_q        <= (state_d == S_VNU_RD);
            vnu_rd_finish_q    <= (state_d == S_WR_WAIT);
            iter_update_q      <= (state_d == S_ITER_UP);
            busy_q             <= (state_d != S_IDLE);
            done_q             <= (state_d == S_DONE);
        end
    end

    assign vnu_init_load_en_o = vnu_init_load_en_q;
    assign vnu_rd_en_o        = vnu_rd_en_q;
    assign vnu_rd_finish_o    = vnu_rd_finish_q;
    assign iter_update_o      = iter_update_q;
    assign iter_cnt_o         = iter_cnt_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign err_o              = err_q;

endmodule

// File: tb/tb_vnu_iter_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_vnu_iter_ctrl_fsm
//
// Each codeword is described by a plan (INIT_LOAD dwell, per-iteration write
// acknowledge delay or timeout, early-stop iteration, idle gap). From the plan
// the bench derives, cycle by cycle, the inputs to drive and the output vector
// the controller must show. Inputs that must be ignored (start_i while busy,
// early_stop_i outside ITER_UP, acknowledges outside their state, pipe_load_i)
// are toggled randomly.
// -----------------------------------------------------------------------------
module tb_vnu_iter_ctrl_fsm;

    localparam int MAX_ITER   = 10;
    localparam int ITER_W     = 4;
    localparam int RD_CYCLES  = 4;
    localparam int RD_CNT_W   = 3;
    localparam int WR_TIMEOUT = 15;

    logic              read_clk = 1'b0;
    logic              rstn     = 1'b1;
    logic              start_i = 1'b0, early_stop_i = 1'b0, vnu_wr_i = 1'b0;
    logic              init_load_i = 1'b0, pipe_load_i = 1'b0;
    logic              vnu_init_load_en_o, vnu_rd_en_o, vnu_rd_finish_o;
    logic              iter_update_o, busy_o, done_o, err_o;
    logic [ITER_W-1:0] iter_cnt_o;

    always #5 read_clk = ~read_clk;

    vnu_iter_ctrl_fsm #(
        .MAX_ITER  (MAX_ITER),
        .ITER_W    (ITER_W),
        .RD_CYCLES (RD_CYCLES),
        .RD_CNT_W  (RD_CNT_W),
        .WR_TIMEOUT(WR_TIMEOUT)
    ) dut (
        .read_clk          (read_clk),
        .rstn              (rstn),
        .start_i           (start_i),
        .early_stop_i      (early_stop_i),
        .vnu_wr_i          (vnu_wr_i),
        .init_load_i       (init_load_i),
        .pipe_load_i       (pipe_load_i),
        .vnu_init_load_en_o(vnu_init_load_en_o),
        .vnu_rd_en_o       (vnu_rd_en_o),
        .vnu_rd_finish_o   (vnu_rd_finish_o),
        .iter_update_o     (iter_update_o),
        .iter_cnt_o        (iter_cnt_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .err_o             (err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: values visible while idle between codewords.
    int model_iter = 0;
    int model_err  = 0;
    int wr_plan [1:MAX_ITER];   // >WR_TIMEOUT means no acknowledge (timeout)
    int start_noise_pct = 20;
    int cw_idx = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output vector layout: {init_en, rd_en, rd_finish, iter_up, busy, done, err, iter_cnt[3:0]}
    function automatic logic [31:0] outs();
        return {21'd0, vnu_init_load_en_o, vnu_rd_en_o, vnu_rd_finish_o, iter_update_o,
                busy_o, done_o, err_o, iter_cnt_o};
    endfunction

    function automatic logic [31:0] expv(bit ini, bit rd, bit fin, bit up, bit bsy,
                                         bit dn, int err, int it);
        logic [3:0] it4;
        it4 = 4'(it);
        return {21'd0, ini, rd, fin, up, bsy, dn, (err != 0), it4};
    endfunction

    function automatic bit nz();
        return ($urandom_range(99) < 25);
    endfunction

    function automatic bit ns();
        return ($urandom_range(99) < start_noise_pct);
    endfunction

    // Called at a falling edge: check this cycle's outputs, drive this
    // cycle's inputs, advance to the next falling edge.
    task automatic cyc(input string tag, input logic [31:0] e,
                       input bit st, input bit il, input bit wr, input bit es);
        check_eq(tag, outs(), e);
        start_i      = st;
        init_load_i  = il;
        vnu_wr_i     = wr;
        early_stop_i = es;
        pipe_load_i  = 1'($urandom_range(1));
        @(negedge read_clk);
    endtask

    task automatic run_codeword(input int il_dwell, input int es_iter, input int gap);
        int  w;
        bit  tmo;
        bit  stop;
        int  iters;
        cyc("idle_start", expv(0,0,0,0,0,0,model_err,model_iter), 1, nz(), nz(), nz());
        model_iter = 0;
        model_err  = 0;
        for (int c = 1; c <= il_dwell; c++)
            cyc("init_load", expv(1,0,0,0,1,0,0,0), ns(), (c == il_dwell), nz(), nz());
        iters = 0;
        for (int k = 1; k <= MAX_ITER; k++) begin
            for (int r = 0; r < RD_CYCLES; r++)
                cyc("vnu_rd", expv(0,1,0,0,1,0,0,model_iter), ns(), nz(), nz(), nz());
            tmo = (wr_plan[k] > WR_TIMEOUT);
            w   = tmo ? WR_TIMEOUT : wr_plan[k];
            for (int c = 1; c <= w; c++)
                cyc("wr_wait", expv(0,0,1,0,1,0,0,model_iter), ns(), nz(), (!tmo && c == w), nz());
            if (tmo) begin
                model_err = 1;
                break;
            end
            stop = (k == es_iter) || (k == MAX_ITER);
            cyc("iter_up", expv(0,0,0,1,1,0,0,model_iter), ns(), nz(), nz(), (k == es_iter));
            model_iter = k;
            iters = k;
            if (stop) break;
        end
        cyc("done", expv(0,0,0,0,1,1,model_err,model_iter), ns(), nz(), nz(), nz());
        for (int g = 0; g < gap; g++)
            cyc("idle", expv(0,0,0,0,0,0,model_err,model_iter), 0, nz(), nz(), nz());
        $display("codeword %0d: il=%0d es=%0d iters=%0d err=%0d", cw_idx, il_dwell, es_iter,
                 iters, model_err);
        cw_idx++;
    endtask

    task automatic plan_all(input int d);
        for (int k = 1; k <= MAX_ITER; k++) wr_plan[k] = d;
    endtask

    // Reset asserted asynchronously in the third VNU_RD cycle of iteration 2.
    task automatic reset_mid_rd();
        plan_all(1);
        cyc("rs_idle", expv(0,0,0,0,0,0,model_err,model_iter), 1, 0, 0, 0);
        cyc("rs_init", expv(1,0,0,0,1,0,0,0), 0, 1, 0, 0);
        for (int r = 0; r < RD_CYCLES; r++)
            cyc("rs_rd1", expv(0,1,0,0,1,0,0,0), 0, 0, 0, 0);
        cyc("rs_wr", expv(0,0,1,0,1,0,0,0), 0, 0, 1, 0);
        cyc("rs_up", expv(0,0,0,1,1,0,0,0), 0, 0, 0, 0);
        for (int r = 0; r < 2; r++)
            cyc("rs_rd2", expv(0,1,0,0,1,0,0,1), 0, 0, 0, 0);
        check_eq("rs_pre", outs(), expv(0,1,0,0,1,0,0,1));
        #2 rstn = 1'b0;
        #1 check_eq("rs_async", outs(), 32'd0);
        model_iter = 0;
        model_err  = 0;
        @(negedge read_clk);
        check_eq("rs_held", outs(), 32'd0);
        @(negedge read_clk);
        rstn = 1'b1;
        for (int c = 0; c < 4; c++)
            cyc("rs_post_idle", expv(0,0,0,0,0,0,0,0), 0, nz(), nz(), nz());
        $display("codeword %0d: reset in VNU_RD of iteration 2", cw_idx);
        cw_idx++;
    endtask

    initial begin
        // Power-on reset, three cycles.
        #1 rstn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge read_clk);
            check_eq("reset", outs(), 32'd0);
        end
        rstn = 1'b1;
        cyc("post_reset_idle", expv(0,0,0,0,0,0,0,0), 0, 0, 0, 0);

        // Full run: 10 iterations, acknowledge in second WR_WAIT cycle.
        start_noise_pct = 0;
        plan_all(2);
        run_codeword(1, 0, 2);
        start_noise_pct = 20;

        // Early stop during the third ITER_UP.
        run_codeword(1, 3, 1);

        // Timeout in the first iteration, then a clean codeword clears err.
        plan_all(2);
        wr_plan[1] = WR_TIMEOUT + 1;
        run_codeword(1, 0, 2);
        plan_all(2);
        run_codeword(2, 2, 1);

        // start_i held high through every busy cycle must be ignored.
        start_noise_pct = 100;
        plan_all(1);
        run_codeword(1, 4, 0);
        start_noise_pct = 20;

        // Acknowledge in the last allowed cycle, timeout in iteration 5,
        // early stop on the final iteration.
        plan_all(WR_TIMEOUT);
        run_codeword(3, 0, 1);
        plan_all(1);
        wr_plan[5] = WR_TIMEOUT + 1;
        run_codeword(1, 0, 0);
        plan_all(1);
        run_codeword(1, MAX_ITER, 2);

        reset_mid_rd();

        // Randomized codewords.
        for (int n = 0; n < 30; n++) begin
            for (int k = 1; k <= MAX_ITER; k++) begin
                int p;
                p = int'($urandom_range(99));
                if (p < 4)       wr_plan[k] = WR_TIMEOUT + 1;
                else if (p < 15) wr_plan[k] = int'($urandom_range(WR_TIMEOUT, 1));
                else             wr_plan[k] = int'($urandom_range(4, 1));
            end
            run_codeword(int'($urandom_range(4, 1)),
                         ($urandom_range(1) == 1) ? int'($urandom_range(MAX_ITER, 1)) : 0,
                         int'($urandom_range(3, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #2000000;
        $display("FAIL timeout: got no end of test, expected end before time limit");
        $fatal(1, "simulation time limit reached");
    end

endmodule
